mavgw: RTL and testbench
========================

MAVGW -- requirements
Module: mavgw

Interface
REQ-001 The block SHALL have parameter IW, default 8, giving the input/output sample width (signed two's complement).
REQ-002 The block SHALL have parameter LGN, default 2, giving window length N = 2^LGN samples (LGN 1..8).
REQ-003 The block SHALL have port i_clk  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port i_reset_n  input  1  reset, synchronous and active-low.
REQ-005 The block SHALL have port i_ce  input  1  sample strobe; i_data is consumed only on cycles with i_ce high.
REQ-006 The block SHALL have port i_data  input  IW  signed sample, the delayed sample stream from the delayw stage.
REQ-007 The block SHALL have port o_ce  output  1  one-cycle strobe marking a new o_data value.
REQ-008 The block SHALL have port o_data  output  IW  signed moving average of the last N accepted samples.
REQ-009 The block SHALL have port o_full  output  1  high once N samples have been accepted since reset.

Function
REQ-010 The block SHALL keep a circular sample buffer of N entries of IW bits, with write pointer wptr of LGN bits.
REQ-011 On each i_ce cycle, the block SHALL read buf[wptr] as "old", write i_data to buf[wptr], and increment wptr modulo N (wrapping N-1 to 0).
REQ-012 The block SHALL hold a signed accumulator acc of IW+LGN bits, updated as acc <= acc + i_data - old on each i_ce; it SHALL never overflow at that width.
REQ-013 The block SHALL have two states: FILL (reset state, old forced to 0 regardless of buffer contents) and RUN (old taken from the buffer).
REQ-014 The block SHALL keep a fill counter of LGN+1 bits; FILL SHALL transition to RUN on the i_ce cycle that accepts the Nth sample, and RUN SHALL have no exit except reset.
REQ-015 o_full SHALL be high exactly when the state is RUN.
REQ-016 o_ce SHALL assert exactly one cycle after each i_ce cycle (latency 1); back-to-back i_ce SHALL give back-to-back o_ce.
REQ-017 o_data SHALL equal the updated acc arithmetically shifted right by LGN (truncation toward minus infinity).
REQ-018 o_data SHALL change only in cycles where o_ce is high, and SHALL hold otherwise.
REQ-019 With i_ce low, acc, wptr, buffer, fill count and state SHALL be unchanged.
REQ-020 During FILL, each output SHALL be the sum of the samples accepted so far divided by N, so that the output ramps up with no stale-memory contribution.

Reset
REQ-021 With i_reset_n low at a clock edge, the block SHALL clear acc, wptr and the fill count, set state to FILL, and drive o_ce=0, o_data=0 and o_full=0.
REQ-022 Reset SHALL take priority over a simultaneous i_ce; that sample SHALL be dropped.
REQ-023 Buffer memory SHALL NOT be reset; the FILL gating alone SHALL guarantee correctness after reset, including a reset asserted mid-operation.

Structure
REQ-024 The buffer SHALL be a separate sub-module mavgw_sbuf (single write port, combinational or same-edge read-before-write, N x IW) so it can map to distributed RAM.
REQ-025 No shared package SHALL be used; the derived widths (accumulator IW+LGN, counter LGN+1) SHALL be localparams inside mavgw.

Verification (IW=8, LGN=2, N=4; i_ce high every cycle unless stated)
REQ-026 Step: i_data=8 constant after reset -> o_data 2,4,6,8,8,...; o_full rises with the 4th o_ce.
REQ-027 Impulse: 100 then zeros -> o_data 25,25,25,25,0,0; proves wrap-around of wptr.
REQ-028 Negative/truncation: -1 once then zeros -> o_data -1,-1,-1,-1,0; with -4 constant -> -1,-2,-3,-4,-4.
REQ-029 Strobe gaps: samples 4,4,4,4 with i_ce low between samples -> o_ce only one cycle after each i_ce; o_data 1,2,3,4 and held during gaps.
REQ-030 Reset mid-run: after 6 samples of 127, reset for 1 cycle, then 4 samples of 0 -> o_data 0,0,0,0 with o_full low until the 4th sample.
REQ-031 Extremes: -128 constant, then 127 constant -> o_data settles at -128, then at 127, with no overflow wrap.

Source files
------------

// File: rtl/mavgw_sbuf.sv
// Circular sample store for the moving-average window: N x IW, one write port,
// combinational read so the old sample is available in the same cycle it is overwritten.
module mavgw_sbuf #(
    parameter int IW  = 8,
    parameter int LGN = 2
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [LGN-1:0]        i_addr,
    input  logic signed [IW-1:0]  i_wdata,
    output logic signed [IW-1:0]  o_rdata
);

    localparam int N = 1 << LGN;

    logic signed [IW-1:0] mem_q [N];

    // Read-before-write: the registered write lands after the combinational read is consumed.
    assign o_rdata = mem_q[i_addr];

    // Storage is deliberately left unreset so it can map onto distributed RAM.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_addr] <= i_wdata;
        end
    end

endmodule

// File: rtl/mavgw.sv
// Moving average over the last 2^LGN signed samples using a running sum and a circular buffer.
// A FILL state masks the unreset buffer until the window has been populated once.
module mavgw #(
    parameter int IW  = 8,
    parameter int LGN = 2
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_ce,
    input  logic signed [IW-1:0] i_data,
    output logic                 o_ce,
    output logic signed [IW-1:0] o_data,
    output logic                 o_full
);

    localparam int N  = 1 << LGN;
    localparam int AW = IW + LGN;
    localparam int CW = LGN + 1;

    typedef enum logic {
        S_FILL = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic [LGN-1:0]       wptr_q, wptr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 o_ce_q, o_ce_d;
    logic signed [IW-1:0] o_data_q, o_data_d;

    logic signed [IW-1:0] rdata_s;
    logic signed [IW-1:0] old_s;
    logic signed [AW-1:0] acc_sum_s;
    logic signed [AW-1:0] acc_shr_s;

    mavgw_sbuf #(
        .IW  (IW),
        .LGN (LGN)
    ) u_sbuf (
        .i_clk   (i_clk),
        .i_we    (i_ce & i_reset_n),
        .i_addr  (wptr_q),
        .i_wdata (i_data),
        .o_rdata (rdata_s)
    );

    // Next-state datapath: add the new sample, retire the one leaving the window.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        wptr_d   = wptr_q;
        cnt_d    = cnt_q;
        o_ce_d   = 1'b0;
        o_data_d = o_data_q;

        old_s     = (state_q == S_RUN) ? rdata_s : {IW{1'b0}};
        acc_sum_s = acc_q + {{LGN{i_data[IW-1]}}, i_data} - {{LGN{old_s[IW-1]}}, old_s};
        acc_shr_s = acc_sum_s >>> LGN;

        if (i_ce) begin
            acc_d    = acc_sum_s;
            wptr_d   = wptr_q + LGN'(1);
            o_ce_d   = 1'b1;
            o_data_d = acc_shr_s[IW-1:0];
            if (state_q == S_FILL) begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_FILL;
                end
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            o_ce_d = 1'b0;
        end
    end

    // State and output registers; reset wins over a coincident strobe.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q  <= S_FILL;
            acc_q    <= {AW{1'b0}};
            wptr_q   <= {LGN{1'b0}};
            cnt_q    <= {CW{1'b0}};
            o_ce_q   <= 1'b0;
            o_data_q <= {IW{1'b0}};
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            wptr_q   <= wptr_d;
            cnt_q    <= cnt_d;
            o_ce_q   <= o_ce_d;
            o_data_q <= o_data_d;
        end
    end

    assign o_ce   = o_ce_q;
    assign o_data = o_data_q;
    assign o_full = (state_q == S_RUN);

endmodule

// File: tb/tb_mavgw.sv
// Directed bench for mavgw (IW=8, LGN=2): step, impulse, truncation, strobe gaps,
// mid-run reset and extreme values against hand-computed expectations.
module tb_mavgw;

    logic              i_clk;
    logic              i_reset_n;
    logic              i_ce;
    logic signed [7:0] i_data;
    logic              o_ce;
    logic signed [7:0] o_data;
    logic              o_full;

    int n_checks;
    int n_fail;

    int step_d[6]  = '{8, 8, 8, 8, 8, 8};
    int step_e[6]  = '{2, 4, 6, 8, 8, 8};
    int imp_d[6]   = '{100, 0, 0, 0, 0, 0};
    int imp_e[6]   = '{25, 25, 25, 25, 0, 0};
    int neg1_d[5]  = '{-1, 0, 0, 0, 0};
    int neg1_e[5]  = '{-1, -1, -1, -1, 0};
    int neg4_e[5]  = '{-1, -2, -3, -4, -4};
    int sat_e[6]   = '{31, 63, 95, 127, 127, 127};
    int lo_e[5]    = '{-32, -64, -96, -128, -128};
    int hi_e[5]    = '{-65, -1, 63, 127, 127};

    mavgw #(
        .IW  (8),
        .LGN (2)
    ) dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_ce      (i_ce),
        .i_data    (i_data),
        .o_ce      (o_ce),
        .o_data    (o_data),
        .o_full    (o_full)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic ce, input int d);
        @(negedge i_clk);
        i_ce   = ce;
        i_data = 8'(d);
        @(posedge i_clk);
        #1;
    endtask

    task automatic sample(input string tag, input int d, input int exp_d, input int exp_full);
        cyc(1'b1, d);
        check({tag, "_ce"}, int'(o_ce), 1);
        check({tag, "_data"}, int'(o_data), exp_d);
        check({tag, "_full"}, int'(o_full), exp_full);
    endtask

    task automatic do_reset();
        i_reset_n = 1'b0;
        cyc(1'b0, 0);
        i_reset_n = 1'b1;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        i_reset_n = 1'b0;
        i_ce      = 1'b0;
        i_data    = 8'sd0;
        cyc(1'b0, 0);
        cyc(1'b0, 0);
        check("rst_ce", int'(o_ce), 0);
        check("rst_data", int'(o_data), 0);
        check("rst_full", int'(o_full), 0);
        i_reset_n = 1'b1;
        cyc(1'b0, 0);
        check("idle_ce", int'(o_ce), 0);

        for (int i = 0; i < 6; i++) sample("step", step_d[i], step_e[i], (i >= 3) ? 1 : 0);

        do_reset();
        for (int i = 0; i < 6; i++) sample("impulse", imp_d[i], imp_e[i], (i >= 3) ? 1 : 0);

        do_reset();
        for (int i = 0; i < 5; i++) sample("neg1", neg1_d[i], neg1_e[i], (i >= 3) ? 1 : 0);

        do_reset();
        for (int i = 0; i < 5; i++) sample("neg4", -4, neg4_e[i], (i >= 3) ? 1 : 0);

        // Samples separated by idle cycles: output must hold with no strobe.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            sample("gap", 4, i + 1, (i == 3) ? 1 : 0);
            cyc(1'b0, 99);
            check("gap_idle_ce", int'(o_ce), 0);
            check("gap_hold", int'(o_data), i + 1);
        end

        // Mid-run reset with a coincident strobe that must be dropped.
        do_reset();
        for (int i = 0; i < 6; i++) sample("sat", 127, sat_e[i], (i >= 3) ? 1 : 0);
        i_reset_n = 1'b0;
        cyc(1'b1, 127);
        i_reset_n = 1'b1;
        check("midrst_ce", int'(o_ce), 0);
        check("midrst_data", int'(o_data), 0);
        check("midrst_full", int'(o_full), 0);
        for (int i = 0; i < 5; i++) sample("refill", 0, 0, (i >= 3) ? 1 : 0);

        do_reset();
        for (int i = 0; i < 5; i++) sample("lo", -128, lo_e[i], (i >= 3) ? 1 : 0);
        for (int i = 0; i < 5; i++) sample("hi", 127, hi_e[i], 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
